// File: rtl/coffee_brew_sequencer.sv
// coffee_brew_sequencer: runs the heater/grinder/pump/milk-valve phases for one paid drink,
// tracks coffee and milk stock, and holds a single pending request that arrives mid-brew.
// Ports: clk_i/reset_i (async, active-high); brew_req_i + drink_sel_i request a drink;
//   temp_ok_i, abort_i, fault_clear_i steer the sequence; refill_*_i reload stock to capacity;
//   actuator enables and fault_o are Moore decodes of the state; *_o pulses are registered;
//   coffee/milk levels and their low-stock flags are reported continuously.
module coffee_brew_sequencer #(
    parameter int GRIND_CYC    = 4,
    parameter int BREW_CYC     = 6,
    parameter int MILK_CYC     = 3,
    parameter int HEAT_TIMEOUT = 15,
    parameter int COFFEE_CAP   = 50,
    parameter int MILK_CAP     = 30,
    parameter int LOW_THRESH   = 5
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       brew_req_i,
    input  logic [1:0] drink_sel_i,
    input  logic       temp_ok_i,
    input  logic       abort_i,
    input  logic       fault_clear_i,
    input  logic       refill_coffee_i,
    input  logic       refill_milk_i,
    output logic       busy_o,
    output logic       heater_on_o,
    output logic       grinder_on_o,
    output logic       pump_on_o,
    output logic       milk_valve_on_o,
    output logic       brew_done_o,
    output logic       req_reject_o,
    output logic       req_dropped_o,
    output logic       aborted_o,
    output logic       fault_o,
    output logic [7:0] coffee_level_o,
    output logic [7:0] milk_level_o,
    output logic       low_coffee_o,
    output logic       low_milk_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_HEAT, S_GRIND, S_BREW, S_MILK, S_DONE, S_FAULT
    } state_t;

    localparam logic [7:0] C_CAP       = 8'(COFFEE_CAP);
    localparam logic [7:0] M_CAP       = 8'(MILK_CAP);
    localparam logic [7:0] LOW_T       = 8'(LOW_THRESH);
    localparam logic [7:0] HEAT_LAST   = 8'(HEAT_TIMEOUT - 1);
    localparam logic [7:0] BREW_LAST   = 8'(BREW_CYC - 1);
    localparam logic [7:0] GRIND1_LAST = 8'(GRIND_CYC - 1);
    localparam logic [7:0] GRIND2_LAST = 8'(2 * GRIND_CYC - 1);
    localparam logic [7:0] MILK1_LAST  = 8'(MILK_CYC - 1);
    localparam logic [7:0] MILK2_LAST  = 8'(2 * MILK_CYC - 1);

    state_t     state_q;
    logic [7:0] timer_q;
    logic [7:0] coffee_q, milk_q;
    logic       pend_vld_q;
    logic [1:0] pend_sel_q;
    logic       rcp_dbl_q;      // recipe needs two coffee doses
    logic [1:0] rcp_milk_q;     // recipe milk doses (0..2)
    logic       reject_q, dropped_q, aborted_q;

    logic       src_vld;
    logic [1:0] src_sel;
    logic [7:0] need_c, need_m;
    logic       stock_ok;
    logic       accept;
    logic [7:0] coffee_d, milk_d;
    logic       grind_last, milk_last;
    logic       phase_active;

    always_comb begin
        // The pending slot is older than a fresh request, so it is served first.
        src_vld  = brew_req_i | pend_vld_q;
        src_sel  = pend_vld_q ? pend_sel_q : drink_sel_i;
        need_c   = (src_sel == 2'b10) ? 8'd2 : 8'd1;
        case (src_sel)
            2'b01:   need_m = 8'd1;
            2'b11:   need_m = 8'd2;
            default: need_m = 8'd0;
        endcase
        stock_ok = (coffee_q >= need_c) && (milk_q >= need_m);
        accept   = (state_q == S_IDLE) && src_vld && stock_ok;

        coffee_d = coffee_q;
        milk_d   = milk_q;
        if (accept) begin
            coffee_d = coffee_q - need_c;
            milk_d   = milk_q - need_m;
        end
        // A refill wins over a same-cycle deduction.
        if (refill_coffee_i) coffee_d = C_CAP;
        if (refill_milk_i)   milk_d   = M_CAP;

        grind_last   = (timer_q == (rcp_dbl_q ? GRIND2_LAST : GRIND1_LAST));
        milk_last    = (timer_q == ((rcp_milk_q == 2'd2) ? MILK2_LAST : MILK1_LAST));
        phase_active = (state_q == S_HEAT) || (state_q == S_GRIND) ||
                       (state_q == S_BREW) || (state_q == S_MILK);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            timer_q    <= 8'd0;
            coffee_q   <= C_CAP;
            milk_q     <= M_CAP;
            pend_vld_q <= 1'b0;
            pend_sel_q <= 2'b00;
            rcp_dbl_q  <= 1'b0;
            rcp_milk_q <= 2'd0;
            reject_q   <= 1'b0;
            dropped_q  <= 1'b0;
            aborted_q  <= 1'b0;
        end else begin
            reject_q  <= 1'b0;
            dropped_q <= 1'b0;
            aborted_q <= 1'b0;
            coffee_q  <= coffee_d;
            milk_q    <= milk_d;

            case (state_q)
                S_IDLE: begin
                    if (src_vld) begin
                        if (stock_ok) begin
                            state_q    <= S_HEAT;
                            timer_q    <= 8'd0;
                            rcp_dbl_q  <= (src_sel == 2'b10);
                            rcp_milk_q <= need_m[1:0];
                        end else begin
                            reject_q <= 1'b1;
                        end
                    end
                    // Pending entry is consumed (served or rejected); a concurrent
                    // fresh request takes its place.
                    if (pend_vld_q) begin
                        pend_vld_q <= brew_req_i;
                        pend_sel_q <= drink_sel_i;
                    end
                end
                S_HEAT: begin
                    if (temp_ok_i) begin
                        state_q <= S_GRIND;
                        timer_q <= 8'd0;
                    end else if (timer_q == HEAT_LAST) begin
                        state_q <= S_FAULT;
                        timer_q <= 8'd0;
                    end else begin
                        timer_q <= timer_q + 8'd1;
                    end
                end
                S_GRIND: begin
                    if (grind_last) begin
                        state_q <= S_BREW;
                        timer_q <= 8'd0;
                    end else begin
                        timer_q <= timer_q + 8'd1;
                    end
                end
                S_BREW: begin
                    if (timer_q == BREW_LAST) begin
                        state_q <= (rcp_milk_q != 2'd0) ? S_MILK : S_DONE;
                        timer_q <= 8'd0;
                    end else begin
                        timer_q <= timer_q + 8'd1;
                    end
                end
                S_MILK: begin
                    if (milk_last) begin
                        state_q <= S_DONE;
                        timer_q <= 8'd0;
                    end else begin
                        timer_q <= timer_q + 8'd1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                S_FAULT: begin
                    pend_vld_q <= 1'b0;
                    if (fault_clear_i) state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    timer_q <= 8'd0;
                end
            endcase

            // Abort is assigned last so it overrides any phase-end transition.
            if (abort_i && phase_active) begin
                state_q   <= S_IDLE;
                timer_q   <= 8'd0;
                aborted_q <= 1'b1;
            end

            // Requests outside IDLE: park one, drop the rest; FAULT never parks.
            if (brew_req_i && (state_q != S_IDLE)) begin
                if ((state_q != S_FAULT) && !pend_vld_q) begin
                    pend_vld_q <= 1'b1;
                    pend_sel_q <= drink_sel_i;
                end else begin
                    dropped_q <= 1'b1;
                end
            end
        end
    end

    assign busy_o          = (state_q != S_IDLE) || pend_vld_q;
    assign heater_on_o     = (state_q == S_HEAT) || (state_q == S_BREW);
    assign grinder_on_o    = (state_q == S_GRIND);
    assign pump_on_o       = (state_q == S_BREW);
    assign milk_valve_on_o = (state_q == S_MILK);
    assign brew_done_o     = (state_q == S_DONE);
    assign fault_o         = (state_q == S_FAULT);
    assign req_reject_o    = reject_q;
    assign req_dropped_o   = dropped_q;
    assign aborted_o       = aborted_q;
    assign coffee_level_o  = coffee_q;
    assign milk_level_o    = milk_q;
    assign low_coffee_o    = (coffee_q <= LOW_T);
    assign low_milk_o      = (milk_q <= LOW_T);

endmodule
